// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - beat-driven note sequencer reading a song ROM; SONG_LOOP_EN selects looping at the end marker
// Feature macro: SONG_LOOP_EN (restart the song at the 8'hFF end marker instead of stopping)
module song_sequencer #(
    parameter int SONG_W = 2,
    parameter int PTR_W  = 7
) (
    input  logic                    clk_1m,
    input  logic                    rst,
    input  logic                    beat,
    input  logic                    play,
    input  logic                    next,
    input  logic [7:0]              rom_data,
    output logic [SONG_W+PTR_W-1:0] rom_addr,
    output logic [4:0]              tone_code,
    output logic                    tone_load,
    output logic [15:0]             display_num,
    output logic                    playing
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;

    logic [2:0]        state;
    logic [SONG_W-1:0] song;
    logic [PTR_W-1:0]  ptr;
    logic              pending;
    logic              end_marker;
    logic [4:0]        note_code;
    logic [3:0]        song_disp;

    assign end_marker  = (rom_data == 8'hFF);
    // Codes with any of the top three bits set are not playable notes and map to silence.
    assign note_code   = (rom_data[7:5] == 3'b000) ? rom_data[4:0] : 5'd0;
    assign rom_addr    = {song, ptr};
    assign playing     = (state == S_WAIT) || (state == S_FETCH) || (state == S_LOAD);
    assign song_disp   = 4'(song) + 4'd1;
    assign display_num = {song_disp, 7'b0, tone_code};

    always_ff @(posedge clk_1m or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            song      <= '0;
            ptr       <= '0;
            pending   <= 1'b0;
            tone_code <= 5'd0;
            tone_load <= 1'b0;
        end else begin
            tone_load <= 1'b0;
            if (next) begin
                // Song change wins over any play/beat in the same cycle.
                song      <= song + 1'b1;
                ptr       <= '0;
                tone_code <= 5'd0;
                tone_load <= 1'b1;
                pending   <= 1'b0;
                if (state == S_FETCH || state == S_LOAD)
                    state <= S_WAIT;
            end else begin
                case (state)
                    S_IDLE: begin
                        ptr <= '0;
                        if (play)
                            state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (play || pending) begin
                            state     <= S_PAUSE;
                            pending   <= 1'b0;
                            tone_code <= 5'd0;
                            tone_load <= 1'b1;
                        end else if (beat) begin
                            state <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (play)
                            pending <= 1'b1;
                        state <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (play)
                            pending <= 1'b1;
                        if (end_marker) begin
                            ptr <= '0;
`ifdef SONG_LOOP_EN
                            state <= S_FETCH;
`else
                            state     <= S_IDLE;
                            tone_code <= 5'd0;
                            tone_load <= 1'b1;
                            pending   <= 1'b0;
`endif
                        end else begin
                            tone_code <= note_code;
                            tone_load <= 1'b1;
                            ptr       <= ptr + 1'b1;
                            state     <= S_WAIT;
                        end
                    end
                    S_PAUSE: begin
                        if (play)
                            state <= S_WAIT;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
